// File: rtl/lcd_fb_writer.sv
// PPU pixel-stream receiver: tracks screen position, packs 2-bit shades four per byte,
// and writes them to a 160x144 frame buffer through a small stall-absorbing FIFO.

package lcd_fb_writer_pkg;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fb_wr_t;
endpackage

module lcd_fb_writer
  import lcd_fb_writer_pkg::*;
#(
  parameter int unsigned H_PIXELS   = 160,
  parameter int unsigned V_LINES    = 144,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        px_in,
  input  logic              px_valid,
  input  logic [1:0]        ppu_mode,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  input  logic              fb_wr_ready,
  output logic              frame_done,
  input  logic              clr_err,
  output logic              ovf_err,
  output logic              frm_err
);

  localparam int unsigned X_W            = $clog2(H_PIXELS);
  localparam int unsigned Y_W            = $clog2(V_LINES);
  localparam int unsigned BYTES_PER_LINE = H_PIXELS / 4;
  localparam int unsigned LAST_ADDR      = V_LINES * BYTES_PER_LINE - 1;
  localparam int unsigned PTR_W          = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0]  MODE_VBLANK    = 2'd1;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VBL    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [X_W-1:0]     x, x_next;
  logic [Y_W-1:0]     y, y_next;
  logic [DATA_W-1:0]  pack, pack_next, pack_new;
  logic [ADDR_W-1:0]  pix_addr;
  logic               push_req;
  logic               frm_set;
  fb_wr_t             push_entry;

  fb_wr_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               full, pop, push_ok, ovf_set;
  fb_wr_t             head_next;

  assign pix_addr = ADDR_W'(y) * ADDR_W'(BYTES_PER_LINE) + ADDR_W'(x >> 2);

  // Screen-position state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_SYNC;
      x     <= '0;
      y     <= '0;
      pack  <= '0;
    end else begin
      state <= state_next;
      x     <= x_next;
      y     <= y_next;
      pack  <= pack_next;
    end
  end

  // Next-state, pixel packing and push request
  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    pack_next  = pack;
    push_req   = 1'b0;
    frm_set    = 1'b0;
    pack_new   = pack;
    pack_new[{x[1:0], 1'b0} +: 2] = px_in;
    push_entry.addr = pix_addr;
    push_entry.data = pack_new;

    case (state)
      ST_SYNC: begin
        if (ppu_mode == MODE_VBLANK) state_next = ST_VBL;
      end
      ST_VBL: begin
        if (ppu_mode != MODE_VBLANK) begin
          state_next = ST_ACTIVE;
          x_next     = '0;
          y_next     = '0;
          pack_next  = '0;
        end
      end
      ST_ACTIVE: begin
        // Early V_BLANK aborts the frame; the partial byte is dropped
        if (ppu_mode == MODE_VBLANK) begin
          frm_set    = 1'b1;
          pack_next  = '0;
          state_next = ST_VBL;
        end else if (px_valid) begin
          pack_next = pack_new;
          if (x[1:0] == 2'd3) begin
            push_req  = 1'b1;
            pack_next = '0;
          end
          if (x == X_W'(H_PIXELS - 1)) begin
            x_next = '0;
            if (y == Y_W'(V_LINES - 1)) begin
              y_next     = '0;
              state_next = ST_VBL;
            end else begin
              y_next = y + Y_W'(1);
            end
          end else begin
            x_next = x + X_W'(1);
          end
        end
      end
      default: state_next = ST_SYNC;
    endcase
  end

  // FIFO control; a full FIFO still accepts a push when the head pops the same cycle
  always_comb begin
    full        = (count == CNT_W'(FIFO_DEPTH));
    pop         = fb_wr_en && fb_wr_ready;
    push_ok     = push_req && (!full || pop);
    ovf_set     = push_req && !push_ok;
    count_next  = count + CNT_W'(push_ok) - CNT_W'(pop);
    rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    head_next   = (push_ok && (wr_ptr == rd_ptr_next)) ? push_entry : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Registered write port mirrors the next FIFO head; holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_wr_en   <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      fb_wr_en <= (count_next != '0);
      if (count_next != '0) begin
        fb_addr <= head_next.addr;
        fb_data <= head_next.data;
      end
      frame_done <= pop && (fb_addr == ADDR_W'(LAST_ADDR));
      ovf_err    <= ovf_set | (ovf_err & ~clr_err);
      frm_err    <= frm_set | (frm_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_lcd_fb_writer.sv
// Directed self-checking bench for lcd_fb_writer.

module tb_lcd_fb_writer;

  logic        clk;
  logic        rst;
  logic [1:0]  px_in;
  logic        px_valid;
  logic [1:0]  ppu_mode;
  logic        fb_wr_en;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_wr_ready;
  logic        frame_done;
  logic        clr_err;
  logic        ovf_err;
  logic        frm_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          fd_cnt = 0;

  lcd_fb_writer #(.H_PIXELS(160), .V_LINES(144), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .px_in      (px_in),
    .px_valid   (px_valid),
    .ppu_mode   (ppu_mode),
    .fb_wr_en   (fb_wr_en),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_wr_ready(fb_wr_ready),
    .frame_done (frame_done),
    .clr_err    (clr_err),
    .ovf_err    (ovf_err),
    .frm_err    (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted write and every frame_done pulse
  always @(negedge clk) begin
    if (!rst && fb_wr_en && fb_wr_ready) begin
      wr_addr_q.push_back(fb_addr);
      wr_data_q.push_back(fb_data);
    end
    if (!rst && frame_done) fd_cnt = fd_cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    px_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic send_px(input logic [1:0] p, input logic [1:0] mode);
    px_in    = p;
    px_valid = 1'b1;
    ppu_mode = mode;
    cyc();
    px_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    px_valid = 1'b0;
    ppu_mode = 2'd0;
    clr_err  = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic start_frame();
    px_valid = 1'b0;
    ppu_mode = 2'd1;
    cyc();
    ppu_mode = 2'd3;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    n_tests++; if (fb_wr_en !== 1'b0)     begin n_fail++; $display("FAIL reset_wr_en got %b want 0", fb_wr_en); end
    n_tests++; if (fb_addr !== 13'd0)     begin n_fail++; $display("FAIL reset_addr got %0d want 0", fb_addr); end
    n_tests++; if (fb_data !== 8'h00)     begin n_fail++; $display("FAIL reset_data got %h want 00", fb_data); end
    n_tests++; if (frame_done !== 1'b0)   begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_tests++; if (ovf_err !== 1'b0)      begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
    n_tests++; if (frm_err !== 1'b0)      begin n_fail++; $display("FAIL reset_frm got %b want 0", frm_err); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_sync_ignore();
    int base;
    base = wr_addr_q.size();
    fb_wr_ready = 1'b1;
    for (int i = 0; i < 23040; i++) send_px(2'(i), (i[0]) ? 2'd3 : 2'd2);
    idle(3);
    n_tests++; if (wr_addr_q.size() - base !== 0) begin n_fail++; $display("FAIL sync_no_writes got %0d want 0", wr_addr_q.size() - base); end
    n_tests++; if (fb_wr_en !== 1'b0) begin n_fail++; $display("FAIL sync_wr_en got %b want 0", fb_wr_en); end
  endtask

  task automatic test_full_frame();
    int base, fd_base, n, bad;
    logic [1:0] p;
    logic [7:0] exp_d;
    base    = wr_addr_q.size();
    fd_base = fd_cnt;
    fb_wr_ready = 1'b1;
    px_valid = 1'b0;
    ppu_mode = 2'd1;
    cyc();
    ppu_mode = 2'd0;
    cyc();
    for (int yy = 0; yy < 144; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        p = (yy == 1 && xx >= 156) ? 2'd3 : 2'(xx);
        send_px(p, 2'd3);
        if (yy == 0 && xx == 2) begin
          n_tests++; if (fb_wr_en !== 1'b0) begin n_fail++; $display("FAIL early_wr_en got %b want 0", fb_wr_en); end
        end
        if (yy == 0 && xx == 3) begin
          n_tests++; if (fb_wr_en !== 1'b1) begin n_fail++; $display("FAIL first_wr_en got %b want 1", fb_wr_en); end
          n_tests++; if (fb_addr !== 13'd0) begin n_fail++; $display("FAIL first_addr got %0d want 0", fb_addr); end
          n_tests++; if (fb_data !== 8'hE4) begin n_fail++; $display("FAIL first_data got %h want e4", fb_data); end
        end
      end
    end
    n_tests++; if (frame_done !== 1'b0 || fb_addr !== 13'd5759) begin n_fail++; $display("FAIL last_byte fd=%b addr=%0d want fd=0 addr=5759", frame_done, fb_addr); end
    idle(1);
    n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done_pulse got %b want 1", frame_done); end
    idle(1);
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_clear got %b want 0", frame_done); end
    idle(3);
    n = wr_addr_q.size() - base;
    n_tests++; if (n !== 5760) begin n_fail++; $display("FAIL frame_write_count got %0d want 5760", n); end
    bad = 0;
    for (int i = 0; i < n && i < 5760; i++) begin
      exp_d = (i == 79) ? 8'hFF : 8'hE4;
      if (wr_addr_q[base+i] !== 13'(i) || wr_data_q[base+i] !== exp_d) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL frame_order got %0d bad entries want 0", bad); end
    if (n > 79) begin
      n_tests++; if (wr_addr_q[base+79] !== 13'd79 || wr_data_q[base+79] !== 8'hFF) begin n_fail++; $display("FAIL addr79 got %0d/%h want 79/ff", wr_addr_q[base+79], wr_data_q[base+79]); end
    end
    n_tests++; if (fd_cnt - fd_base !== 1) begin n_fail++; $display("FAIL frame_done_count got %0d want 1", fd_cnt - fd_base); end
  endtask

  task automatic test_stall();
    int base, n, bad, stable_bad;
    logic [1:0] s;
    do_reset();
    fb_wr_ready = 1'b0;
    start_frame();
    base = wr_addr_q.size();
    stable_bad = 0;
    for (int i = 0; i < 40; i++) begin
      send_px(2'(i / 4), 2'd3);
      if (i >= 3 && (fb_wr_en !== 1'b1 || fb_addr !== 13'd0 || fb_data !== 8'h00)) stable_bad++;
      if (i == 31) begin
        n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full got %b want 0", ovf_err); end
      end
      if (i == 35) begin
        n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_on_drop got %b want 1", ovf_err); end
      end
    end
    n_tests++; if (stable_bad !== 0) begin n_fail++; $display("FAIL stall_stable got %0d unstable cycles want 0", stable_bad); end
    n_tests++; if (wr_addr_q.size() - base !== 0) begin n_fail++; $display("FAIL stall_no_pop got %0d want 0", wr_addr_q.size() - base); end
    fb_wr_ready = 1'b1;
    idle(12);
    n = wr_addr_q.size() - base;
    n_tests++; if (n !== 8) begin n_fail++; $display("FAIL stall_kept_count got %0d want 8", n); end
    bad = 0;
    for (int i = 0; i < n; i++) begin
      s = 2'(i);
      if (wr_addr_q[base+i] !== 13'(i) || wr_data_q[base+i] !== {s, s, s, s}) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL stall_order got %0d bad want 0", bad); end
    n_tests++; if (fb_wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_drained got %b want 0", fb_wr_en); end
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", ovf_err); end
  endtask

  task automatic test_frame_abort();
    int base, fd_base, n, bad;
    do_reset();
    fb_wr_ready = 1'b1;
    start_frame();
    base    = wr_addr_q.size();
    fd_base = fd_cnt;
    for (int i = 0; i < 50 * 160 + 77; i++) send_px(2'(i), 2'd3);
    send_px(2'd1, 2'd1);
    n_tests++; if (frm_err !== 1'b1) begin n_fail++; $display("FAIL frm_err_set got %b want 1", frm_err); end
    ppu_mode = 2'd3;
    idle(4);
    n = wr_addr_q.size() - base;
    n_tests++; if (n !== 2019) begin n_fail++; $display("FAIL abort_count got %0d want 2019", n); end
    bad = 0;
    for (int i = 0; i < n; i++)
      if (wr_addr_q[base+i] !== 13'(i) || wr_data_q[base+i] !== 8'hE4) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL abort_order got %0d bad want 0", bad); end
    n_tests++; if (fd_cnt - fd_base !== 0) begin n_fail++; $display("FAIL abort_frame_done got %0d want 0", fd_cnt - fd_base); end
    base = wr_addr_q.size();
    for (int i = 0; i < 4; i++) send_px(2'(i), 2'd3);
    idle(3);
    n_tests++; if (wr_addr_q.size() - base !== 1) begin n_fail++; $display("FAIL restart_count got %0d want 1", wr_addr_q.size() - base); end
    if (wr_addr_q.size() > base) begin
      n_tests++; if (wr_addr_q[base] !== 13'd0 || wr_data_q[base] !== 8'hE4) begin n_fail++; $display("FAIL restart_byte got %0d/%h want 0/e4", wr_addr_q[base], wr_data_q[base]); end
    end
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    n_tests++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL frm_clear got %b want 0", frm_err); end
  endtask

  task automatic test_back_to_back();
    int base, n, bad;
    do_reset();
    fb_wr_ready = 1'b0;
    start_frame();
    base = wr_addr_q.size();
    for (int i = 0; i < 35; i++) send_px(2'(i / 4), 2'd3);
    fb_wr_ready = 1'b1;
    send_px(2'd0, 2'd3);
    fb_wr_ready = 1'b0;
    n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got %b want 0", ovf_err); end
    n_tests++; if (fb_addr !== 13'd1 || fb_wr_en !== 1'b1) begin n_fail++; $display("FAIL b2b_head got %0d en=%b want 1 en=1", fb_addr, fb_wr_en); end
    fb_wr_ready = 1'b1;
    idle(12);
    n = wr_addr_q.size() - base;
    n_tests++; if (n !== 9) begin n_fail++; $display("FAIL b2b_count got %0d want 9", n); end
    bad = 0;
    for (int i = 0; i < n; i++)
      if (wr_addr_q[base+i] !== 13'(i)) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_order got %0d bad want 0", bad); end
    n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf_end got %b want 0", ovf_err); end
  endtask

  task automatic test_async_reset();
    int base;
    do_reset();
    fb_wr_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 8; i++) send_px(2'(i), 2'd3);
    n_tests++; if (fb_wr_en !== 1'b1) begin n_fail++; $display("FAIL pre_rst_wr_en got %b want 1", fb_wr_en); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (fb_wr_en !== 1'b0) begin n_fail++; $display("FAIL async_rst_wr_en got %b want 0", fb_wr_en); end
    n_tests++; if (fb_addr !== 13'd0 || fb_data !== 8'h00) begin n_fail++; $display("FAIL async_rst_out got %0d/%h want 0/00", fb_addr, fb_data); end
    cyc();
    rst = 1'b0;
    fb_wr_ready = 1'b1;
    base = wr_addr_q.size();
    for (int i = 0; i < 16; i++) send_px(2'(i), 2'd3);
    idle(3);
    n_tests++; if (wr_addr_q.size() - base !== 0) begin n_fail++; $display("FAIL post_rst_ignore got %0d want 0", wr_addr_q.size() - base); end
    start_frame();
    for (int i = 0; i < 4; i++) send_px(2'(i), 2'd3);
    idle(3);
    n_tests++; if (wr_addr_q.size() - base !== 1) begin n_fail++; $display("FAIL post_rst_count got %0d want 1", wr_addr_q.size() - base); end
    if (wr_addr_q.size() > base) begin
      n_tests++; if (wr_addr_q[base] !== 13'd0 || wr_data_q[base] !== 8'hE4) begin n_fail++; $display("FAIL post_rst_byte got %0d/%h want 0/e4", wr_addr_q[base], wr_data_q[base]); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    px_in       = 2'd0;
    px_valid    = 1'b0;
    ppu_mode    = 2'd0;
    fb_wr_ready = 1'b0;
    clr_err     = 1'b0;
    test_reset();
    test_sync_ignore();
    test_full_frame();
    test_stall();
    test_frame_abort();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_fb_writer.md
Name: lcd_fb_writer

Overview:
- Receiver for the PPU pixel stream: consumes 2-bit shade pixels from PPU3 (PX_OUT/PX_valid) together with PPU_MODE.
- Tracks screen position, packs 4 pixels per byte and writes a 160x144 frame buffer (5760 bytes) through a ready/valid write port.
- A small FIFO absorbs frame-buffer stalls.
- Sits between PPU3 and the display scan-out memory.

Parameters:
- H_PIXELS, 160, pixels per line (multiple of 4)
- V_LINES, 144, visible lines per frame
- FIFO_DEPTH, 8, packed-byte FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- px_in  in  2  pixel shade from PPU
- px_valid  in  1  px_in valid this cycle
- ppu_mode  in  2  0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW
- fb_wr_en  out  1  write request (FIFO head valid)
- fb_addr  out  13  byte address = y*(H_PIXELS/4) + x/4
- fb_data  out  8  packed pixels; pixel x%4==k in bits [2k+1:2k]
- fb_wr_ready  in  1  frame buffer accepts the write this cycle
- frame_done  out  1  one-cycle pulse, last byte of frame written
- clr_err  in  1  clears sticky flags
- ovf_err  out  1  sticky: byte dropped, FIFO full
- frm_err  out  1  sticky: V_BLANK before frame complete

Behaviour:
- Reset (async): state=SYNC, x=0, y=0, pack register=0, FIFO empty, fb_wr_en=0, fb_addr=0, fb_data=0, frame_done=0, ovf_err=0, frm_err=0.
- State machine:
  - SYNC: pixels ignored; ppu_mode==1 -> VBL.
  - VBL: pixels ignored; ppu_mode!=1 -> ACTIVE with x=0, y=0, pack cleared.
  - ACTIVE: each px_valid cycle accepts one pixel. px_in is written into pack slot x%4, then x increments.
    - x%4==3: the byte {addr, pack-with-new-pixel} is pushed to the FIFO in the same cycle.
    - x==H_PIXELS-1: x<=0, y<=y+1.
    - Last pixel (x=159, y=143): -> VBL.
    - ppu_mode==1 while ACTIVE with frame incomplete: frm_err<=1, partial pack discarded (not pushed), -> VBL.
- px_valid with ppu_mode≠3 in ACTIVE is still accepted; mode only gates via the V_BLANK rule.
- FIFO:
  - Push and pop on the same clock edge are allowed.
  - When full, a push succeeds only if a pop occurs the same cycle. Otherwise the byte is dropped, ovf_err<=1, and the x/y counters still advance.
  - Output registers are driven from the FIFO head: fb_wr_en = not empty.
  - Pop when fb_wr_en && fb_wr_ready.
  - fb_addr/fb_data hold stable while fb_wr_en=1 and fb_wr_ready=0.
- Latency: byte pushed on edge N (4th pixel) into an empty FIFO -> fb_wr_en=1 with that byte during cycle N+1.
- frame_done: asserted the cycle after the pop of address 5759. Not asserted if that byte was dropped. Exactly one pulse per frame.
- clr_err=1 clears both sticky flags on the next edge. A simultaneous new error event wins (flag stays 1).
- Address arithmetic: y*40 + (x>>2), 13-bit unsigned, max 5759; no wrap within a frame.

Test Plan:
- Reset then 160x144 pixels before any V_BLANK -> no fb_wr_en at all; after mode 1 -> 0 -> full frame of 23040 pixels with fb_wr_ready=1 -> exactly 5760 writes at addresses 0..5759 in order, one frame_done pulse.
- Pixels 0,1,2,3 at x=0..3, y=0 -> fb_addr=0, fb_data=8'hE4, visible one cycle after 4th pixel. Pixel pattern 3,3,3,3 at y=1, x=156..159 -> addr 79, data 8'hFF.
- fb_wr_ready=0 for 40 cycles with a continuous pixel stream (10 bytes, FIFO_DEPTH=8) -> first 8 bytes retained in order, next 2 dropped, ovf_err=1; fb_addr/fb_data stable while stalled.
- ppu_mode=1 at y=50, x=77 -> frm_err=1, no byte for addr 50*40+19, no frame_done; next frame starts at addr 0. clr_err -> frm_err=0.
- Push and pop in the same cycle with FIFO full and fb_wr_ready=1 -> no drop, ovf_err stays 0, order preserved.
- Async rst asserted mid-line with FIFO non-empty -> fb_wr_en=0 immediately (before the next clk edge); after release, pixels ignored until the next V_BLANK -> non-V_BLANK sequence.
